// File: rtl/boa_sim_pkg.sv
// boa_sim_pkg: shared state encoding, trap cause codes and fail codes for the simulation monitor.
package boa_sim_pkg;

   typedef enum logic [2:0] {
      S_HOLD,
      S_RUN,
      S_PASS,
      S_FAIL,
      S_TIMEOUT
   } state_e;

   localparam logic [4:0]  CAUSE_EBREAK     = 5'd3;
   localparam logic [4:0]  CAUSE_MECALL     = 5'd11;
   localparam logic [30:0] EBREAK_FAIL_CODE = 31'h7FFF_FFFF;

   function automatic logic is_terminal(input state_e s);
      return s == S_PASS || s == S_FAIL || s == S_TIMEOUT;
   endfunction

endpackage

// File: rtl/boa_bus_logger.sv
// boa_bus_logger: prints data-bus writes, reads and the terminal verdict.
// Compiled only when BOA_SIM_MONITOR_LOG_EN is defined.
`ifdef BOA_SIM_MONITOR_LOG_EN
module boa_bus_logger
   import boa_sim_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bus_re,
   input  logic [3:0]  bus_we,
   input  logic [29:0] bus_addr,
   input  logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  state_e      state,
   input  logic [30:0] fail_code
);

   logic        rd_q, rd_d;
   logic [29:0] rd_addr_q, rd_addr_d;
   state_e      prev_q, prev_d;

   always_comb begin
      rd_d      = bus_re;
      rd_addr_d = bus_addr;
      prev_d    = state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q      <= 1'b0;
         rd_addr_q <= '0;
         prev_q    <= S_HOLD;
      end else begin
         rd_q      <= rd_d;
         rd_addr_q <= rd_addr_d;
         prev_q    <= prev_d;
         if (|bus_we)
            $display("WRITE 0x%08h = 0x%08h mask 0b%04b", {bus_addr, 2'b00}, bus_wdata, bus_we);
         if (rd_q)
            $display("READ 0x%08h = 0x%08h", {rd_addr_q, 2'b00}, bus_rdata);
         if (is_terminal(state) && state != prev_q)
            $display("MONITOR %s code 0x%08h", state.name(), fail_code);
      end
   end

endmodule
`endif

// File: rtl/boa_sim_monitor.sv
// boa_sim_monitor: holds the core in reset, then watches tohost writes and traps for a verdict.
// Define BOA_SIM_MONITOR_LOG_EN to build in the bus/verdict logger.
module boa_sim_monitor
   import boa_sim_pkg::*;
#(
   parameter logic [31:0] TOHOST_ADDR = 32'h8000_1000,
   parameter int unsigned TIMEOUT     = 100000,
   parameter int unsigned RST_CYCLES  = 4,
   parameter int unsigned CW          = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          bus_re,
   input  logic [3:0]    bus_we,
   input  logic [29:0]   bus_addr,
   input  logic [31:0]   bus_wdata,
   input  logic [31:0]   bus_rdata,
   input  logic          trap,
   input  logic [4:0]    trap_cause,
   output logic          core_rst,
   output logic          done,
   output logic          pass,
   output logic [30:0]   fail_code,
   output logic          timed_out,
   output logic [CW-1:0] cycles
);

   state_e        state_q, state_d;
   logic [7:0]    hold_q, hold_d;
   logic [CW-1:0] cycles_q, cycles_d;
   logic [30:0]   fail_code_q, fail_code_d;
   logic          hit;

   always_comb begin
      hit         = bus_we == 4'hF && {bus_addr, 2'b00} == TOHOST_ADDR;
      state_d     = state_q;
      hold_d      = hold_q;
      cycles_d    = cycles_q;
      fail_code_d = fail_code_q;
      if (state_q == S_HOLD) begin
         hold_d = hold_q + 8'd1;
         if (hold_q == 8'(RST_CYCLES - 1)) state_d = S_RUN;
      end else if (state_q == S_RUN) begin
         // tohost writes with bit 0 clear are not verdicts, so a trap in the same cycle still counts
         if (hit && bus_wdata == 32'd1) begin
            state_d = S_PASS;
         end else if (hit && bus_wdata[0]) begin
            state_d     = S_FAIL;
            fail_code_d = bus_wdata[31:1];
         end else if (trap && trap_cause == CAUSE_EBREAK) begin
            state_d     = S_FAIL;
            fail_code_d = EBREAK_FAIL_CODE;
         end else if (trap && trap_cause == CAUSE_MECALL) begin
            state_d = S_PASS;
         end else if (TIMEOUT != 0 && cycles_q == CW'(TIMEOUT)) begin
            state_d = S_TIMEOUT;
         end else if (cycles_q != '1) begin
            cycles_d = cycles_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_HOLD;
         hold_q      <= '0;
         cycles_q    <= '0;
         fail_code_q <= '0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         cycles_q    <= cycles_d;
         fail_code_q <= fail_code_d;
      end
   end

   assign core_rst  = state_q == S_HOLD;
   assign done      = is_terminal(state_q);
   assign pass      = state_q == S_PASS;
   assign timed_out = state_q == S_TIMEOUT;
   assign fail_code = fail_code_q;
   assign cycles    = cycles_q;

`ifdef BOA_SIM_MONITOR_LOG_EN
   boa_bus_logger u_logger (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus_re    (bus_re),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .state     (state_q),
      .fail_code (fail_code_q)
   );
`else
   logic unused_bus;
   assign unused_bus = ^{bus_re, bus_rdata};
`endif

endmodule
